// File: rtl/fixed_unroller_pkg.sv
// Shared helpers for activation-path components: beat count and beat-counter sizing.
package fixed_unroller_pkg;

    function automatic int calc_beats(input int out_num, input int in_num);
        return (in_num > 0) ? (out_num / in_num) : 1;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fixed_unroller.sv
// Re-packs IN_NUM-element beats into OUT_NUM-element vectors behind one output holding register.
// Latency: data_out_valid rises 1 cycle after the final beat is accepted.
// Backpressure: early beats keep collecting while the output is held; only the final beat stalls.
module fixed_unroller
    import fixed_unroller_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 1,
    parameter int OUT_NUM    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [IN_NUM],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [OUT_NUM],
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    localparam int BEATS = calc_beats(OUT_NUM, IN_NUM);
    localparam int CNT_W = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam int LAST_BASE = (BEATS - 1) * IN_NUM;

    typedef logic [DATA_WIDTH-1:0] elem_t;

    generate
        if (IN_NUM < 1 || (OUT_NUM % IN_NUM) != 0) begin : g_bad_cfg
            $error("fixed_unroller: OUT_NUM must be a multiple of IN_NUM (IN_NUM >= 1)");
        end
    endgenerate

    elem_t            col_buf [OUT_NUM];
    elem_t            merged  [OUT_NUM];
    logic [CNT_W-1:0] cnt;
    logic             last_beat;
    logic             in_fire;
    logic             out_fire;

    assign last_beat     = (cnt == LAST_CNT);
    assign data_in_ready = rst && (!last_beat || !data_out_valid || data_out_ready);
    assign in_fire       = data_in_valid && data_in_ready;
    assign out_fire      = data_out_valid && data_out_ready;

    // The final beat bypasses the collection buffer straight into the output register.
    always_comb begin
        merged = col_buf;
        for (int j = 0; j < IN_NUM; j++) begin
            merged[LAST_BASE + j] = data_in[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt            <= '0;
            data_out_valid <= 1'b0;
            for (int i = 0; i < OUT_NUM; i++) begin
                data_out[i] <= '0;
                col_buf[i]  <= '0;
            end
        end else begin
            if (in_fire) begin
                for (int b = 0; b < BEATS; b++) begin
                    for (int j = 0; j < IN_NUM; j++) begin
                        if (cnt == CNT_W'(b)) begin
                            col_buf[b * IN_NUM + j] <= data_in[j];
                        end
                    end
                end
                if (last_beat) begin
                    data_out <= merged;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A final beat landing in the same cycle as an output handshake keeps valid high.
            if (in_fire && last_beat) begin
                data_out_valid <= 1'b1;
            end else if (out_fire) begin
                data_out_valid <= 1'b0;
            end
        end
    end

    logic [OUT_NUM*DATA_WIDTH-1:0] out_flat;

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < OUT_NUM; i++) begin
            out_flat[i*DATA_WIDTH +: DATA_WIDTH] = data_out[i];
        end
    end

    a_out_hold: assert property (@(posedge clk) disable iff (!rst)
        (data_out_valid && !data_out_ready) |=> (data_out_valid && $stable(out_flat)));

    a_cnt_range: assert property (@(posedge clk) int'(cnt) < BEATS);

endmodule

// File: tb/tb_fixed_unroller.sv
// Bench for fixed_unroller: 1->4 unroll, 2->4 unroll and 2->2 register slice instances.
module tb_fixed_unroller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0] a_in [1];
    logic       a_in_vld, a_in_rdy;
    logic [7:0] a_out [4];
    logic       a_out_vld, a_out_rdy;

    logic [7:0] b_in [2];
    logic       b_in_vld, b_in_rdy;
    logic [7:0] b_out [4];
    logic       b_out_vld, b_out_rdy;

    logic [7:0] c_in [2];
    logic       c_in_vld, c_in_rdy;
    logic [7:0] c_out [2];
    logic       c_out_vld, c_out_rdy;

    fixed_unroller #(.DATA_WIDTH(8), .IN_NUM(1), .OUT_NUM(4)) u_a (
        .clk(clk), .rst(rst),
        .data_in(a_in), .data_in_valid(a_in_vld), .data_in_ready(a_in_rdy),
        .data_out(a_out), .data_out_valid(a_out_vld), .data_out_ready(a_out_rdy)
    );

    fixed_unroller #(.DATA_WIDTH(8), .IN_NUM(2), .OUT_NUM(4)) u_b (
        .clk(clk), .rst(rst),
        .data_in(b_in), .data_in_valid(b_in_vld), .data_in_ready(b_in_rdy),
        .data_out(b_out), .data_out_valid(b_out_vld), .data_out_ready(b_out_rdy)
    );

    fixed_unroller #(.DATA_WIDTH(8), .IN_NUM(2), .OUT_NUM(2)) u_c (
        .clk(clk), .rst(rst),
        .data_in(c_in), .data_in_valid(c_in_vld), .data_in_ready(c_in_rdy),
        .data_out(c_out), .data_out_valid(c_out_vld), .data_out_ready(c_out_rdy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int a_flat();
        return int'({a_out[3], a_out[2], a_out[1], a_out[0]});
    endfunction

    function automatic int b_flat();
        return int'({b_out[3], b_out[2], b_out[1], b_out[0]});
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard for instance A: accepted beats form expected vectors, handshakes pop them.
    int         qa [$];
    logic [7:0] a_col [4];
    int         a_n = 0;
    int         a_vecs = 0;
    int         a_last = 0;
    int         a_hs_cyc [$];
    int         a_stall_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            a_n = 0;
        end else begin
            if (a_in_vld && !a_in_rdy) a_stall_seen++;
            if (a_in_vld && a_in_rdy) begin
                a_col[a_n] = a_in[0];
                a_n++;
                if (a_n == 4) begin
                    qa.push_back(int'({a_col[3], a_col[2], a_col[1], a_col[0]}));
                    a_n = 0;
                end
            end
            if (a_out_vld && a_out_rdy) begin
                a_vecs++;
                a_last = a_flat();
                a_hs_cyc.push_back(cyc);
                if (qa.size() == 0) check("a_sb_underflow", 0, 1);
                else check("a_vec", a_flat(), qa.pop_front());
            end
        end
    end

    // Scoreboard for instance C.
    int qc [$];
    int c_pops = 0;
    bit c_rand_en = 1'b0;

    always @(negedge clk) begin
        if (rst && c_out_vld && c_out_rdy) begin
            c_pops++;
            if (qc.size() == 0) check("c_sb_underflow", 0, 1);
            else check("c_vec", int'({c_out[1], c_out[0]}), qc.pop_front());
        end
    end

    always @(posedge clk) begin
        if (c_rand_en) begin
            #1 c_out_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic send_a(input logic [7:0] v, output int stalls);
        bit ok;
        a_in[0] = v;
        a_in_vld = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            ok = a_in_rdy;
            @(posedge clk);
            #1;
            if (ok) break;
            stalls++;
            if (stalls > 50) begin
                check("a_send_timeout", 32'(ok), 1);
                break;
            end
        end
        a_in_vld = 1'b0;
    endtask

    task automatic send_c(input logic [15:0] v);
        bit ok;
        int waits;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        c_in[0] = v[7:0];
        c_in[1] = v[15:8];
        c_in_vld = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            ok = c_in_rdy;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 50) begin
                check("c_send_timeout", 32'(ok), 1);
                break;
            end
        end
        c_in_vld = 1'b0;
        if (ok) begin
            qc.push_back(int'(v));
            check("c_latency", int'({c_out_vld, c_out[1], c_out[0]}), int'({1'b1, v}));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, v0, h0, s0;
        rst = 1'b0;
        a_in[0] = '0; a_in_vld = 1'b0; a_out_rdy = 1'b1;
        b_in[0] = '0; b_in[1] = '0; b_in_vld = 1'b0; b_out_rdy = 1'b1;
        c_in[0] = '0; c_in[1] = '0; c_in_vld = 1'b0; c_out_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_rdy_low", 32'(a_in_rdy), 0);
        check("rst_out_vld_low", 32'(a_out_vld), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_rdy_high", 32'(a_in_rdy), 1);
        check("rst_out_zero", a_flat(), 0);
        check("rst_b_in_rdy", 32'(b_in_rdy), 1);
        check("rst_c_out_vld", 32'(c_out_vld), 0);
        @(posedge clk); #1;

        // Streaming 0x00..0x0F with ready held high
        v0 = a_vecs; h0 = a_hs_cyc.size(); s0 = a_stall_seen;
        for (int v = 0; v < 16; v++) begin
            send_a(8'(v), st);
            if (v == 3) begin
                check("t2_first_vld", 32'(a_out_vld), 1);
                check("t2_first_vec", a_flat(), 32'h03020100);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("t2_vec_count", a_vecs - v0, 4);
        check("t2_no_stall", a_stall_seen - s0, 0);
        check("t2_last_vec", a_last, 32'h0F0E0D0C);
        if (a_hs_cyc.size() >= h0 + 4) check("t2_spacing", a_hs_cyc[h0+3] - a_hs_cyc[h0], 12);
        else check("t2_spacing_missing", a_hs_cyc.size(), h0 + 4);

        // Back-pressure on the final beat
        a_out_rdy = 1'b0;
        for (int v = 1; v <= 4; v++) send_a(8'(v), st);
        check("t3_vec1_vld", 32'(a_out_vld), 1);
        check("t3_vec1", a_flat(), 32'h04030201);
        for (int v = 5; v <= 7; v++) begin
            send_a(8'(v), st);
            check("t3_early_accept", st, 0);
        end
        a_in[0] = 8'h08;
        a_in_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_rdy_low", 32'(a_in_rdy), 0);
            check("t3_vld_hold", 32'(a_out_vld), 1);
            check("t3_dat_hold", a_flat(), 32'h04030201);
        end
        @(posedge clk); #1;
        a_out_rdy = 1'b1;
        @(negedge clk);
        check("t3_rdy_release", 32'(a_in_rdy), 1);
        @(posedge clk); #1;
        a_in_vld = 1'b0;
        check("t3_no_bubble_vld", 32'(a_out_vld), 1);
        check("t3_vec2", a_flat(), 32'h08070605);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a vector
        send_a(8'h11, st);
        send_a(8'h22, st);
        rst = 1'b0;
        @(negedge clk);
        check("t1_rdy_in_rst", 32'(a_in_rdy), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("t1_vld_after_rst", 32'(a_out_vld), 0);
        check("t1_dat_after_rst", a_flat(), 0);
        v0 = a_vecs;
        for (int v = 'hA1; v <= 'hA4; v++) send_a(8'(v), st);
        repeat (2) @(posedge clk);
        #1;
        check("t1_vec_count", a_vecs - v0, 1);
        check("t1_vec", a_last, 32'hA4A3A2A1);

        // Sparse input
        v0 = a_vecs;
        for (int v = 'hF0; v <= 'hF3; v++) begin
            send_a(8'(v), st);
            if (v == 'hF2) check("t6_no_early_vld", 32'(a_out_vld), 0);
            if (v == 'hF3) check("t6_vld", 32'(a_out_vld), 1);
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("t6_vec_count", a_vecs - v0, 1);
        check("t6_vec", a_last, 32'hF3F2F1F0);

        // Two-element beats into a four-element vector
        b_in[0] = 8'h10; b_in[1] = 8'h11; b_in_vld = 1'b1;
        @(negedge clk);
        check("t4_rdy_beat0", 32'(b_in_rdy), 1);
        @(posedge clk); #1;
        b_in[0] = 8'h12; b_in[1] = 8'h13;
        @(negedge clk);
        check("t4_rdy_beat1", 32'(b_in_rdy), 1);
        @(posedge clk); #1;
        b_in_vld = 1'b0;
        check("t4_vld", 32'(b_out_vld), 1);
        check("t4_vec", b_flat(), 32'h13121110);
        b_out_rdy = 1'b0;
        b_in[0] = 8'h20; b_in[1] = 8'h21; b_in_vld = 1'b1;
        @(negedge clk);
        check("t4_bp_beat0_rdy", 32'(b_in_rdy), 1);
        @(posedge clk); #1;
        b_in[0] = 8'h22; b_in[1] = 8'h23;
        @(negedge clk);
        check("t4_bp_final_rdy", 32'(b_in_rdy), 0);
        check("t4_bp_hold", b_flat(), 32'h13121110);
        @(posedge clk); #1;
        b_out_rdy = 1'b1;
        @(posedge clk); #1;
        b_in_vld = 1'b0;
        check("t4_vec2_vld", 32'(b_out_vld), 1);
        check("t4_vec2", b_flat(), 32'h23222120);

        // Single-beat vectors with random valid/ready
        c_rand_en = 1'b1;
        for (int k = 0; k < 64; k++) send_c(16'($urandom));
        c_rand_en = 1'b0;
        @(posedge clk); #2;
        c_out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_pop_count", c_pops, 64);
        check("t5_sb_empty", qc.size(), 0);
        check("t5_a_sb_empty", qa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fixed_unroller.md
Name: fixed_unroller

Overview:
- Downstream companion of the activation lookup stage.
- The lookup stage emits ROLL_NUM elements per beat after its roller. This block re-packs consecutive beats into one full-parallelism vector of OUT_NUM elements, so the next layer sees the original tensor parallelism again.
- It is a counter-indexed collection buffer followed by one output holding register, with valid/ready on both sides.
- It sustains one input beat per cycle under no back-pressure.

Parameters:
- DATA_WIDTH, 8, bit width of each element (equals DATA_OUT_0_PRECISION_0 of the lookup stage).
- IN_NUM, 1, elements per input beat (the roller's ROLL_NUM); must be ≥1.
- OUT_NUM, 4, elements per output vector; OUT_NUM % IN_NUM must be 0 (checked by elaboration assertion).
- BEATS (localparam), OUT_NUM/IN_NUM, input beats per output vector.
- CNT_W (localparam), max(1,$clog2(BEATS)), beat counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- data_in  input  [DATA_WIDTH-1:0] x IN_NUM (unpacked)  element beat from the lookup stage.
- data_in_valid  input  1  beat valid.
- data_in_ready  output  1  beat accepted when valid && ready.
- data_out  output  [DATA_WIDTH-1:0] x OUT_NUM (unpacked)  reassembled vector.
- data_out_valid  output  1  vector valid.
- data_out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst==0 at an edge):
  - cnt=0, data_out_valid=0, all data_out elements=0, collection buffer=0.
  - Reset has priority over every other event. A partially collected vector is discarded.
  - data_in_ready is 0 while rst==0.
- Placement rule: beat k (k=cnt) of a vector writes element j of data_in to vector index k*IN_NUM+j. Lowest indices arrive first.
- data_in_ready = rst && ((cnt != BEATS-1) || !data_out_valid || data_out_ready). This is combinational from registered state and data_out_ready; it has no dependence on data_in_valid.
- Accept with cnt < BEATS-1: write the beat into the collection buffer; cnt <= cnt+1.
- Accept with cnt == BEATS-1:
  - data_out <= collection buffer with the final beat merged in.
  - data_out_valid <= 1; cnt <= 0.
- Output handshake (data_out_valid && data_out_ready) with no simultaneous final-beat accept: data_out_valid <= 0. data_out keeps its value; it is don't-care when invalid.
- Simultaneous output handshake and final-beat accept: the new vector loads and data_out_valid stays 1. No bubble.
- Latency: data_out_valid rises 1 cycle after the final beat is accepted.
- Throughput: under continuous valid and continuous ready, one vector every BEATS cycles. No beat is ever dropped.
- Back-pressure:
  - While data_out_valid=1 and data_out_ready=0, the block still accepts beats 0..BEATS-2 into the collection buffer.
  - It stalls only on the final beat, so at most one full vector plus BEATS-1 beats are buffered.
- Stability: while data_out_valid=1 and data_out_ready=0, data_out and data_out_valid are held constant.
- BEATS==1 case:
  - cnt is constant 0; the block degenerates to a single register slice.
  - data_in_ready = !data_out_valid || data_out_ready.
- Input data is ignored when data_in_valid=0 or data_in_ready=0.
- No arithmetic on element values; elements pass bit-exact.

Decomposition:
- Shared package (activation components package) holds:
  - a helper function computing BEATS and the counter width;
  - the element typedef logic [DATA_WIDTH-1:0] (parameterised via a macro or typedef in the instantiating scope).
- No sub-module needed. The collection buffer, counter and output register stay in one module, together about 150 lines with assertions.
- Elaboration assertion: OUT_NUM % IN_NUM == 0.
- Simulation assertions:
  - data_out stable while valid && !ready;
  - cnt < BEATS at all times.

Test Plan:
1. Reset mid-vector (IN_NUM=1, OUT_NUM=4): feed 0x11,0x22, then rst=0 for 1 cycle, then feed 0xA1,0xA2,0xA3,0xA4 -> exactly one vector {idx0..3}={0xA1,0xA2,0xA3,0xA4}. data_out_valid=0 during and just after reset.
2. Streaming with data_out_ready=1: feed 0x00..0x0F continuously -> 4 vectors, first valid the cycle after 0x03 is accepted. Vectors are {00,01,02,03} ... {0C,0D,0E,0F}, one every 4 cycles; data_in_ready constantly 1.
3. Back-pressure: data_out_ready=0 after first vector {01,02,03,04}, input continues 05..08 -> 05,06,07 accepted, data_in_ready=0 while 08 is offered, data_out held at {01,02,03,04}. Raise ready -> 08 is accepted in the same cycle and the next vector {05,06,07,08} appears with no bubble.
4. IN_NUM=2, OUT_NUM=4: beats {0x10,0x11},{0x12,0x13} -> data_out[0..3]={0x10,0x11,0x12,0x13}.
5. BEATS==1 (IN_NUM=OUT_NUM=2) with random valid/ready toggling on 64 beats -> output sequence equals input sequence, no loss or duplication, 1-cycle latency.
6. Sparse input: data_in_valid low on alternate cycles over values 0xF0..0xF3 -> single vector {F0,F1,F2,F3}; cnt does not advance on invalid cycles.
